// File: rtl/gfx_mem_pkg.sv
// rtl/gfx_mem_pkg.sv - shared gfx memory request types and D-cache field widths
package gfx_mem_pkg;

  typedef enum logic [1:0] {
    REQ_LOAD  = 2'd0,
    REQ_STORE = 2'd1
  } req_type_e;

  localparam int DC_ID_W    = 8;
  localparam int ID_REQ_MSB = 7;
  localparam int ID_REQ_LSB = 4;
  localparam int ID_TAG_W   = 4;
  localparam int DC_DATA_W  = 128;
  localparam int DC_STRB_W  = 8;
  localparam int DC_ADDR_W  = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-way round-robin pick starting at a pointer, with wrap-around
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] eligible,
  input  logic [3:0]   ptr,
  output logic [N-1:0] grant_oh,
  output logic [3:0]   grant_idx,
  output logic         grant_any
);

  // Scan offsets 0..N-1 from ptr; the first eligible position wins.
  always_comb begin
    logic [4:0] pos;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + 5'(k);
      if (pos >= 5'(N)) pos = pos - 5'(N);
      for (int i = 0; i < N; i++) begin
        if (!grant_any && pos == 5'(i) && eligible[i]) begin
          grant_oh[i] = 1'b1;
          grant_idx   = 4'(i);
          grant_any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gfx_dc_port_arb.sv
// rtl/gfx_dc_port_arb.sv - round-robin share of the gfx/tex D-cache port with load tracking
module gfx_dc_port_arb
  import gfx_mem_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_type,
  input  logic [32*N_REQ-1:0]    req_addr,
  input  logic [128*N_REQ-1:0]   req_wdata,
  input  logic [8*N_REQ-1:0]     req_wstrb,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [DC_DATA_W-1:0]   resp_data,
  output logic                   resp_err,
  output logic                   dc_req_valid,
  output logic [1:0]             dc_req_type,
  output logic [DC_ADDR_W-1:0]   dc_req_addr,
  output logic [DC_DATA_W-1:0]   dc_req_wdata,
  output logic [DC_STRB_W-1:0]   dc_req_wstrb,
  output logic [DC_ID_W-1:0]     dc_req_id,
  input  logic                   dc_req_ready,
  input  logic                   dc_resp_valid,
  input  logic [DC_DATA_W-1:0]   dc_resp_data,
  input  logic [DC_ID_W-1:0]     dc_resp_id,
  input  logic                   dc_resp_err,
  output logic                   orphan_err,
  output logic                   busy
);

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e              state, state_nxt;
  logic [3:0]          rr_ptr, hold_idx, hold_nxt, arb_idx, sel_idx;
  logic [N_REQ-1:0]    eligible, arb_oh, hold_oh, sel_oh;
  logic                arb_any, sel_valid, sel_load, handshake, cnt_any;
  logic [1:0]          sel_type;
  logic [31:0]         sel_addr;
  logic [127:0]        sel_wdata;
  logic [7:0]          sel_wstrb;
  logic [ID_TAG_W-1:0] sel_tag;
  logic [3:0]          resp_req;
  logic [ID_TAG_W-1:0] unused_resp_tag;
  logic [3:0]          out_cnt [N_REQ];
  logic [ID_TAG_W-1:0] tag     [N_REQ];

  // Eligibility: stores always, loads only below the outstanding limit; decode held index.
  always_comb begin
    eligible = '0;
    hold_oh  = '0;
    cnt_any  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid[i] &&
                    (req_type[2*i +: 2] != 2'(REQ_LOAD) || out_cnt[i] < 4'(MAX_OUT));
      hold_oh[i]  = (hold_idx == 4'(i));
      cnt_any     = cnt_any || (out_cnt[i] != 4'd0);
    end
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  // Select the granted lane: fresh arbitration in IDLE, the locked lane in HOLD.
  always_comb begin
    sel_oh    = (state == ST_HOLD) ? hold_oh : arb_oh;
    sel_idx   = (state == ST_HOLD) ? hold_idx : arb_idx;
    sel_valid = (state == ST_HOLD) ? |(hold_oh & req_valid) : arb_any;
    sel_type  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    sel_tag   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_oh[i]) begin
        sel_type  = req_type[2*i +: 2];
        sel_addr  = req_addr[32*i +: 32];
        sel_wdata = req_wdata[128*i +: 128];
        sel_wstrb = req_wstrb[8*i +: 8];
        sel_tag   = tag[i];
      end
    end
    sel_load = (sel_type == 2'(REQ_LOAD));
  end

  // Drive the cache port; everything is forced quiet while reset is asserted.
  always_comb begin
    dc_req_valid = sel_valid && rst_n;
    dc_req_type  = dc_req_valid ? sel_type  : '0;
    dc_req_addr  = dc_req_valid ? sel_addr  : '0;
    dc_req_wdata = dc_req_valid ? sel_wdata : '0;
    dc_req_wstrb = dc_req_valid ? sel_wstrb : '0;
    dc_req_id    = dc_req_valid ? {sel_idx, sel_tag} : '0;
    handshake    = dc_req_valid && dc_req_ready;
    req_ready    = handshake ? sel_oh : '0;
  end

  // Route a load response to the requester named in its ID if it has a load in flight.
  always_comb begin
    resp_req        = dc_resp_id[ID_REQ_MSB:ID_REQ_LSB];
    unused_resp_tag = dc_resp_id[ID_TAG_W-1:0];
    resp_valid      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      resp_valid[i] = rst_n && dc_resp_valid && resp_req == 4'(i) && out_cnt[i] != 4'd0;
    end
    resp_data = rst_n ? dc_resp_data : '0;
    resp_err  = rst_n && dc_resp_err;
    busy      = (state == ST_HOLD) || cnt_any;
  end

  // FSM state register and held grant index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_idx <= '0;
    end else begin
      state    <= state_nxt;
      hold_idx <= hold_nxt;
    end
  end

  // Lock the winner when the cache stalls; release on the handshake.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_idx;
    case (state)
      ST_IDLE: begin
        if (dc_req_valid && !dc_req_ready) begin
          state_nxt = ST_HOLD;
          hold_nxt  = arb_idx;
        end
      end
      ST_HOLD: begin
        if (handshake) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Round-robin pointer, per-requester tags, outstanding-load counts and sticky orphan flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      orphan_err <= 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        out_cnt[i] <= '0;
        tag[i]     <= '0;
      end
    end else begin
      if (handshake) rr_ptr <= (sel_idx == 4'(N_REQ - 1)) ? 4'd0 : sel_idx + 4'd1;
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i]) tag[i] <= tag[i] + 1'b1;
        case ({req_ready[i] && sel_load, resp_valid[i]})
          2'b10:   out_cnt[i] <= out_cnt[i] + 4'd1;
          2'b01:   out_cnt[i] <= out_cnt[i] - 4'd1;
          default: out_cnt[i] <= out_cnt[i];
        endcase
      end
      if (dc_resp_valid && !(|resp_valid)) orphan_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gfx_dc_port_arb.sv
// tb/tb_gfx_dc_port_arb.sv - directed self-checking bench for gfx_dc_port_arb
module tb_gfx_dc_port_arb;

  localparam int N = 2;
  localparam logic [1:0] LD = 2'd0;
  localparam logic [1:0] ST = 2'd1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_type;
  logic [32*N-1:0]  req_addr;
  logic [128*N-1:0] req_wdata;
  logic [8*N-1:0]   req_wstrb;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [127:0]   resp_data;
  logic           resp_err;
  logic           dc_req_valid;
  logic [1:0]     dc_req_type;
  logic [31:0]    dc_req_addr;
  logic [127:0]   dc_req_wdata;
  logic [7:0]     dc_req_wstrb;
  logic [7:0]     dc_req_id;
  logic           dc_req_ready;
  logic           dc_resp_valid;
  logic [127:0]   dc_resp_data;
  logic [7:0]     dc_resp_id;
  logic           dc_resp_err;
  logic           orphan_err;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gfx_dc_port_arb #(.N_REQ(N), .MAX_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_type(req_type), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .dc_req_valid(dc_req_valid), .dc_req_type(dc_req_type), .dc_req_addr(dc_req_addr),
    .dc_req_wdata(dc_req_wdata), .dc_req_wstrb(dc_req_wstrb), .dc_req_id(dc_req_id),
    .dc_req_ready(dc_req_ready), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .dc_resp_id(dc_resp_id), .dc_resp_err(dc_resp_err),
    .orphan_err(orphan_err), .busy(busy)
  );

  task automatic set_req(input int i, input logic v, input logic [1:0] t,
                         input logic [31:0] a, input logic [7:0] s);
    req_valid[i]          = v;
    req_type[2*i +: 2]    = t;
    req_addr[32*i +: 32]  = a;
    req_wdata[128*i +: 128] = {4{a}};
    req_wstrb[8*i +: 8]   = s;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_type = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_data = '0;
    dc_resp_id = '0; dc_resp_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, ST, 32'h10, 8'hFF);
    set_req(1, 1'b1, LD, 32'h20, 8'h00);
    dc_req_ready = 1'b1; dc_resp_valid = 1'b1; dc_resp_id = 8'h10;
    #1;
    checks++; if (dc_req_valid !== 1'b0) begin failures++; $display("FAIL reset_dc_req_valid got=%b exp=0", dc_req_valid); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%b exp=00", resp_valid); end
    checks++; if (busy !== 1'b0 || orphan_err !== 1'b0) begin failures++; $display("FAIL reset_busy_orphan got=%b%b exp=00", busy, orphan_err); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (orphan_err !== 1'b0) begin failures++; $display("FAIL reset_orphan_after got=%b exp=0", orphan_err); end
  endtask

  task automatic test_single_store();
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, ST, 32'h1000, 8'h0F);
    dc_req_ready = 1'b1;
    #1;
    checks++; if (dc_req_valid !== 1'b1) begin failures++; $display("FAIL store_valid got=%b exp=1", dc_req_valid); end
    checks++; if (dc_req_addr !== 32'h1000 || dc_req_wstrb !== 8'h0F || dc_req_type !== ST) begin
      failures++; $display("FAIL store_fields got addr=%h strb=%h type=%0d exp 1000/0f/1", dc_req_addr, dc_req_wstrb, dc_req_type); end
    checks++; if (dc_req_wdata !== {4{32'h1000}}) begin failures++; $display("FAIL store_wdata got=%h", dc_req_wdata); end
    checks++; if (dc_req_id !== 8'h00 || req_ready !== 2'b01) begin failures++; $display("FAIL store_id_ready got id=%h rdy=%b exp 00/01", dc_req_id, req_ready); end
    @(negedge clk);
    set_req(1, 1'b1, ST, 32'h1100, 8'hF0);
    #1;
    checks++; if (dc_req_id !== 8'h10 || req_ready !== 2'b10) begin failures++; $display("FAIL store_rrptr got id=%h rdy=%b exp 10/10", dc_req_id, req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL store_busy got=%b exp=0", busy); end
  endtask

  task automatic test_contention();
    logic [7:0] exp_id [4];
    logic [1:0] exp_rdy [4];
    exp_id  = '{8'h00, 8'h10, 8'h01, 8'h11};
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_req(0, 1'b1, ST, 32'h3000, 8'h01);
      set_req(1, 1'b1, ST, 32'h4000, 8'h02);
      dc_req_ready = 1'b1;
      #1;
      checks++; if (dc_req_id !== exp_id[k] || req_ready !== exp_rdy[k]) begin
        failures++; $display("FAIL contention_%0d got id=%h rdy=%b exp id=%h rdy=%b", k, dc_req_id, req_ready, exp_id[k], exp_rdy[k]); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    @(negedge clk);
    set_req(1, 1'b1, LD, 32'h2000, 8'h00);
    dc_req_ready = 1'b0;
    #1;
    checks++; if (dc_req_valid !== 1'b1 || dc_req_id !== 8'h10 || req_ready !== 2'b00) begin
      failures++; $display("FAIL hold_c1 got v=%b id=%h rdy=%b exp 1/10/00", dc_req_valid, dc_req_id, req_ready); end
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      set_req(0, 1'b1, ST, 32'h5000, 8'hFF);
      #1;
      checks++; if (dc_req_id !== 8'h10 || dc_req_addr !== 32'h2000 || dc_req_type !== LD || req_ready !== 2'b00) begin
        failures++; $display("FAIL hold_c%0d got id=%h addr=%h type=%0d rdy=%b exp 10/2000/0/00", k, dc_req_id, dc_req_addr, dc_req_type, req_ready); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy_c%0d got=%b exp=1", k, busy); end
    end
    @(negedge clk);
    dc_req_ready = 1'b1;
    #1;
    checks++; if (dc_req_id !== 8'h10 || req_ready !== 2'b10) begin failures++; $display("FAIL hold_accept got id=%h rdy=%b exp 10/10", dc_req_id, req_ready); end
    @(negedge clk);
    set_req(1, 1'b0, LD, 32'h0, 8'h00);
    #1;
    checks++; if (dc_req_id !== 8'h00 || req_ready !== 2'b01 || dc_req_addr !== 32'h5000) begin
      failures++; $display("FAIL hold_next got id=%h rdy=%b addr=%h exp 00/01/5000", dc_req_id, req_ready, dc_req_addr); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL hold_busy_load got=%b exp=1", busy); end
  endtask

  task automatic test_outstanding();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_req(1, 1'b1, LD, 32'h6000 + 32'(k), 8'h00);
      dc_req_ready = 1'b1;
      #1;
      checks++; if (dc_req_id !== 8'h10 + 8'(k) || req_ready !== 2'b10) begin
        failures++; $display("FAIL outst_load%0d got id=%h rdy=%b exp id=%h rdy=10", k, dc_req_id, req_ready, 8'h10 + 8'(k)); end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_req(0, 1'b1, ST, 32'h7000, 8'h0F);
      #1;
      checks++; if (dc_req_id !== 8'(k) || req_ready !== 2'b01) begin
        failures++; $display("FAIL outst_store%0d got id=%h rdy=%b exp id=%h rdy=01", k, dc_req_id, req_ready, 8'(k)); end
    end
    @(negedge clk);
    set_req(0, 1'b0, ST, 32'h0, 8'h00);
    dc_resp_valid = 1'b1; dc_resp_id = 8'h12; dc_resp_data = {4{32'h0BAD_F00D}};
    #1;
    checks++; if (dc_req_valid !== 1'b0) begin failures++; $display("FAIL outst_blocked got v=%b exp=0", dc_req_valid); end
    checks++; if (resp_valid !== 2'b10 || resp_data !== {4{32'h0BAD_F00D}}) begin
      failures++; $display("FAIL outst_resp got rv=%b data=%h exp 10", resp_valid, resp_data); end
    @(negedge clk);
    dc_resp_valid = 1'b0;
    #1;
    checks++; if (dc_req_valid !== 1'b1 || dc_req_id !== 8'h14 || req_ready !== 2'b10) begin
      failures++; $display("FAIL outst_fifth got v=%b id=%h rdy=%b exp 1/14/10", dc_req_valid, dc_req_id, req_ready); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_req(1, 1'b1, LD, 32'h8000, 8'h00);
      dc_req_ready = 1'b1;
    end
    @(negedge clk);
    dc_resp_valid = 1'b1; dc_resp_id = 8'h10; dc_resp_err = 1'b0;
    dc_resp_data = {4{32'hDEAD_BEEF}};
    #1;
    checks++; if (req_ready !== 2'b10 || dc_req_id !== 8'h12) begin failures++; $display("FAIL same_accept got rdy=%b id=%h exp 10/12", req_ready, dc_req_id); end
    checks++; if (resp_valid !== 2'b10 || resp_data !== {4{32'hDEAD_BEEF}} || resp_err !== 1'b0) begin
      failures++; $display("FAIL same_resp got rv=%b data=%h err=%b", resp_valid, resp_data, resp_err); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_req(1, 1'b0, LD, 32'h0, 8'h00);
      dc_resp_id = 8'h11 + 8'(k);
      #1;
      checks++; if (resp_valid !== 2'b10) begin failures++; $display("FAIL same_drain%0d got rv=%b exp 10", k, resp_valid); end
    end
    @(negedge clk);
    dc_resp_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || orphan_err !== 1'b0) begin failures++; $display("FAIL same_count got busy=%b orphan=%b exp 0/0", busy, orphan_err); end
  endtask

  task automatic test_orphan();
    logic [7:0] ids [2];
    ids = '{8'h30, 8'h05};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      @(negedge clk);
      dc_resp_valid = 1'b1; dc_resp_id = ids[k];
      #1;
      checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL orphan_rv_%0d got=%b exp=00", k, resp_valid); end
      @(negedge clk);
      dc_resp_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (orphan_err !== 1'b1) begin failures++; $display("FAIL orphan_sticky_%0d got=%b exp=1", k, orphan_err); end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (orphan_err !== 1'b0) begin failures++; $display("FAIL orphan_clear got=%b exp=0", orphan_err); end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_store();
    test_contention();
    test_hold();
    test_outstanding();
    test_same_cycle();
    test_orphan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
